// File: rtl/glitch_filter.sv
// Synchronising glitch filter: a new din level reaches dout only after N_STABLE stable samples.
// Optional glitch counter is built when GLITCH_FILTER_CNT_EN is defined.
module glitch_filter #(
  parameter int N_STABLE = 4,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             din,
  input  logic             clear_cnt,
  output logic             dout,
  output logic             rise,
  output logic             fall,
  output logic             glitch,
  output logic [CNT_W-1:0] glitch_cnt
);

  localparam int SW = $clog2(N_STABLE) + 1;
  localparam logic [SW-1:0] LAST = SW'(N_STABLE - 1);

  typedef enum logic [1:0] {LOW, CHK_HI, HIGH, CHK_LO} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic          s1_q, s2_q;
  logic          dout_q, dout_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic          glitch_q, glitch_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      state_q  <= LOW;
      cnt_q    <= '0;
      dout_q   <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      glitch_q <= 1'b0;
    end else begin
      s1_q     <= din;
      s2_q     <= s1_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      glitch_q <= glitch_d;
    end
  end

  // Strobes are registered so they line up with the dout change.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    glitch_d = 1'b0;
    case (state_q)
      LOW: begin
        if (s2_q) begin
          state_d = CHK_HI;
          cnt_d   = SW'(1);
        end
      end
      CHK_HI: begin
        if (!s2_q) begin
          state_d  = LOW;
          cnt_d    = '0;
          glitch_d = 1'b1;
        end else if (cnt_q == LAST) begin
          state_d = HIGH;
          cnt_d   = '0;
          dout_d  = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + SW'(1);
        end
      end
      HIGH: begin
        if (!s2_q) begin
          state_d = CHK_LO;
          cnt_d   = SW'(1);
        end
      end
      CHK_LO: begin
        if (s2_q) begin
          state_d  = HIGH;
          cnt_d    = '0;
          glitch_d = 1'b1;
        end else if (cnt_q == LAST) begin
          state_d = LOW;
          cnt_d   = '0;
          dout_d  = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + SW'(1);
        end
      end
      default: begin
        state_d = LOW;
        cnt_d   = '0;
      end
    endcase
  end

  assign dout   = dout_q;
  assign rise   = rise_q;
  assign fall   = fall_q;
  assign glitch = glitch_q;

`ifdef GLITCH_FILTER_CNT_EN
  logic [CNT_W-1:0] gcnt_q, gcnt_d;

  // Counts the visible glitch strobe; clear beats a coincident increment.
  always_comb begin
    gcnt_d = gcnt_q;
    if (clear_cnt)
      gcnt_d = '0;
    else if (glitch_q && (gcnt_q != {CNT_W{1'b1}}))
      gcnt_d = gcnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) gcnt_q <= '0;
    else          gcnt_q <= gcnt_d;
  end

  assign glitch_cnt = gcnt_q;
`else
  logic unused_clear_cnt;
  assign unused_clear_cnt = clear_cnt;
  assign glitch_cnt       = '0;
`endif

endmodule

// File: tb/tb_glitch_filter.sv
// Directed bench for glitch_filter (N_STABLE=4, CNT_W=8); expectations follow the build macro.
module tb_glitch_filter;

`ifdef GLITCH_FILTER_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n, din, clear_cnt;
  logic       dout, rise, fall, glitch;
  logic [7:0] glitch_cnt;

  int n_chk = 0;
  int n_bad = 0;
  int g, r, f, dl, dh, multi;

  glitch_filter #(.N_STABLE(4), .CNT_W(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .din       (din),
    .clear_cnt (clear_cnt),
    .dout      (dout),
    .rise      (rise),
    .fall      (fall),
    .glitch    (glitch),
    .glitch_cnt(glitch_cnt)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ecnt(input int v);
    return CNT_EN ? v : 0;
  endfunction

  // One clock edge; inputs change and outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic watch(input int n, output int ng, output int nr, output int nf,
                       output int ndl, output int ndh, output int nm);
    ng = 0; nr = 0; nf = 0; ndl = 0; ndh = 0; nm = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      ng  += int'(glitch);
      nr  += int'(rise);
      nf  += int'(fall);
      ndl += int'(!dout);
      ndh += int'(dout);
      if ((int'(glitch) + int'(rise) + int'(fall)) > 1) nm++;
    end
  endtask

  task automatic pulse_hi();
    din = 1'b1;
    tick();
    din = 1'b0;
    for (int i = 0; i < 4; i++) tick();
  endtask

  initial begin
    reset_n = 1'b0; din = 1'b1; clear_cnt = 1'b0;

    // 1: reset, then release with din already high
    for (int i = 0; i < 3; i++) tick();
    chk("rst_dout", dout, 0);
    chk("rst_cnt", glitch_cnt, 0);
    chk("rst_strobes", int'(rise) + int'(fall) + int'(glitch), 0);
    reset_n = 1'b1;
    watch(5, g, r, f, dl, dh, multi);
    chk("rel_dout_low_e1_5", dl, 5);
    chk("rel_no_early_rise", r, 0);
    tick();
    chk("rel_dout_e6", dout, 1);
    chk("rel_rise_e6", rise, 1);
    tick();
    chk("rel_rise_once", rise, 0);

    // 2: one-cycle low pulse while high
    for (int i = 0; i < 4; i++) tick();
    din = 1'b0; tick(); din = 1'b1;
    watch(8, g, r, f, dl, dh, multi);
    chk("p1_glitch", g, 1);
    chk("p1_dout_held", dl, 0);
    chk("p1_no_fall", f, 0);
    chk("p1_cnt", glitch_cnt, ecnt(1));

    // 3a: low for 3 cycles is rejected
    din = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    din = 1'b1;
    watch(8, g, r, f, dl, dh, multi);
    chk("l3_glitch", g, 1);
    chk("l3_dout_held", dl, 0);
    chk("l3_cnt", glitch_cnt, ecnt(2));

    // 3b: low for 4 cycles is accepted
    din = 1'b0;
    watch(5, g, r, f, dl, dh, multi);
    chk("l4_dout_hi_e1_5", dh, 5);
    tick();
    chk("l4_dout_e6", dout, 0);
    chk("l4_fall_e6", fall, 1);
    watch(6, g, r, f, dl, dh, multi);
    chk("l4_fall_once", f, 0);
    chk("l4_no_glitch", g, 0);
    chk("l4_cnt", glitch_cnt, ecnt(2));

    // 4: saturation, then clear coinciding with a glitch strobe
    multi = 0;
    for (int i = 0; i < 300; i++) pulse_hi();
    chk("sat_dout_low", dout, 0);
    chk("sat_cnt", glitch_cnt, ecnt(255));
    din = 1'b1; tick(); din = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("clr_glitch_seen", glitch, 1);
    clear_cnt = 1'b1; tick(); clear_cnt = 1'b0;
    chk("clr_wins", glitch_cnt, 0);
    for (int i = 0; i < 3; i++) tick();
    pulse_hi();
    chk("post_clr_cnt", glitch_cnt, ecnt(1));

    // 5: reset while CHK_HI with cnt=2
    din = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    reset_n = 1'b0; din = 1'b0;
    #1;
    chk("mid_rst_cnt", glitch_cnt, 0);
    chk("mid_rst_out", int'(dout) + int'(rise) + int'(glitch), 0);
    tick(); tick();
    reset_n = 1'b1;
    watch(10, g, r, f, dl, dh, multi);
    chk("mid_rst_no_rise", r, 0);
    chk("mid_rst_no_glitch", g, 0);
    chk("mid_rst_dout", dh, 0);

    // 6: rerun the one-cycle low pulse from a fresh high level
    din = 1'b1;
    watch(8, g, r, f, dl, dh, multi);
    chk("t6_rise", r, 1);
    din = 1'b0; tick(); din = 1'b1;
    watch(8, g, r, f, dl, dh, multi);
    chk("t6_glitch", g, 1);
    chk("t6_dout_held", dl, 0);
    chk("t6_exclusive", multi, 0);
    chk("t6_cnt", glitch_cnt, ecnt(1));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
